// File: rtl/fb_pkg.sv
// Shared types and helpers for the double-buffered framebuffer controller.
package fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PENDING  = 2'd1,
    ST_CLEARING = 2'd2
  } fb_state_e;

  typedef logic bank_idx_t;

  // Address width for a W x H pixel array, never narrower than one bit.
  function automatic int fb_addr_width(input int w, input int h);
    if (w * h > 1) begin
      return $clog2(w * h);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/fb_bank.sv
// Single-clock pixel RAM: one write port, one read port with a registered output.
module fb_bank
  import fb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_N     = 76800,
  localparam int AW        = fb_addr_width(DATA_N, 1)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DATA_N];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/fb_swap_ctrl.sv
// Double-buffered framebuffer: display reads the front bank, writer fills the back bank,
// flips wait for vsync. Optional post-flip clear of the new back bank: FB_CLEAR_ON_SWAP_EN.
module fb_swap_ctrl
  import fb_pkg::*;
#(
  parameter int                     DISPLAY_WIDTH  = 320,
  parameter int                     DISPLAY_HEIGHT = 240,
  parameter int                     PIXEL_WIDTH    = 16,
  parameter logic [PIXEL_WIDTH-1:0] CLEAR_VALUE    = '0,
  localparam int                    XW             = $clog2(DISPLAY_WIDTH),
  localparam int                    YW             = $clog2(DISPLAY_HEIGHT)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [XW-1:0]          i_rd_x,
  input  logic [YW-1:0]          i_rd_y,
  output logic [PIXEL_WIDTH-1:0] o_rd_data,
  input  logic                   i_wr_en,
  input  logic [XW-1:0]          i_wr_x,
  input  logic [YW-1:0]          i_wr_y,
  input  logic [PIXEL_WIDTH-1:0] i_wr_data,
  output logic                   o_wr_ready,
  input  logic                   i_swap_req,
  input  logic                   i_vsync,
  output logic                   o_swap_pending,
  output logic                   o_swap_done,
  output logic                   o_front_sel
);

  localparam int             NPIX  = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam int             AW    = fb_addr_width(DISPLAY_WIDTH, DISPLAY_HEIGHT);
  // One extra bit so a power-of-two dimension does not wrap to zero.
  localparam logic [XW:0]    X_LIM = (XW + 1)'(DISPLAY_WIDTH);
  localparam logic [YW:0]    Y_LIM = (YW + 1)'(DISPLAY_HEIGHT);
  localparam logic [AW-1:0]  W_AW  = AW'(DISPLAY_WIDTH);

  function automatic logic [AW-1:0] pix_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AW'(x) + W_AW * AW'(y);
  endfunction

  fb_state_e              r_state;
  fb_state_e              w_state_nxt;
  bank_idx_t              r_front_sel;
  bank_idx_t              r_rd_bank;
  logic                   r_rd_ok;
  logic                   r_swap_pending;
  logic                   r_swap_done;
  logic                   w_pending_nxt;
  logic                   w_flip;
  logic                   w_clr_last;
  logic                   w_rd_in;
  logic                   w_wr_in;
  logic                   w_bank_we;
  logic                   w_we0;
  logic                   w_we1;
  logic [AW-1:0]          w_rd_addr;
  logic [AW-1:0]          w_waddr;
  logic [PIXEL_WIDTH-1:0] w_wdata;
  logic [PIXEL_WIDTH-1:0] w_q0;
  logic [PIXEL_WIDTH-1:0] w_q1;

  assign w_rd_in   = ({1'b0, i_rd_x} < X_LIM) && ({1'b0, i_rd_y} < Y_LIM);
  assign w_wr_in   = ({1'b0, i_wr_x} < X_LIM) && ({1'b0, i_wr_y} < Y_LIM);
  assign w_rd_addr = w_rd_in ? pix_addr(i_rd_x, i_rd_y) : '0;

`ifdef FB_CLEAR_ON_SWAP_EN
  logic [AW-1:0] r_clr_addr;

  assign w_clr_last = (r_clr_addr == AW'(NPIX - 1));
  assign o_wr_ready = (r_state != ST_CLEARING);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clr_addr <= '0;
    end else if (r_state == ST_CLEARING && !w_clr_last) begin
      r_clr_addr <= r_clr_addr + AW'(1);
    end else begin
      r_clr_addr <= '0;
    end
  end
`else
  assign w_clr_last = 1'b0;
  assign o_wr_ready = 1'b1;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_swap_pending;
    w_flip        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_swap_req) begin
          w_state_nxt   = ST_PENDING;
          w_pending_nxt = 1'b1;
        end else begin
          w_state_nxt   = ST_IDLE;
        end
      end
      ST_PENDING: begin
        if (i_vsync) begin
          w_flip        = 1'b1;
          w_pending_nxt = 1'b0;
`ifdef FB_CLEAR_ON_SWAP_EN
          w_state_nxt   = ST_CLEARING;
`else
          w_state_nxt   = ST_IDLE;
`endif
        end else begin
          w_state_nxt   = ST_PENDING;
        end
      end
`ifdef FB_CLEAR_ON_SWAP_EN
      ST_CLEARING: begin
        // A request during the sweep is remembered and served once the sweep ends.
        if (i_swap_req) begin
          w_pending_nxt = 1'b1;
        end else begin
          w_pending_nxt = r_swap_pending;
        end
        if (w_clr_last) begin
          w_state_nxt = w_pending_nxt ? ST_PENDING : ST_IDLE;
        end else begin
          w_state_nxt = ST_CLEARING;
        end
      end
`endif
      default: begin
        w_state_nxt   = ST_IDLE;
        w_pending_nxt = 1'b0;
      end
    endcase
  end

  // Back-bank write port: the clear sweep owns it while wr_ready is low.
  always_comb begin
    w_bank_we = i_wr_en && o_wr_ready && w_wr_in;
    w_waddr   = pix_addr(i_wr_x, i_wr_y);
    w_wdata   = i_wr_data;
`ifdef FB_CLEAR_ON_SWAP_EN
    if (r_state == ST_CLEARING) begin
      w_bank_we = 1'b1;
      w_waddr   = r_clr_addr;
      w_wdata   = CLEAR_VALUE;
    end else begin
      w_bank_we = i_wr_en && w_wr_in;
    end
`endif
    w_we0 = w_bank_we && (r_front_sel == 1'b1);
    w_we1 = w_bank_we && (r_front_sel == 1'b0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_front_sel    <= 1'b0;
      r_swap_pending <= 1'b0;
      r_swap_done    <= 1'b0;
      r_rd_ok        <= 1'b0;
      r_rd_bank      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_swap_pending <= w_pending_nxt;
      r_swap_done    <= w_flip;
      r_rd_ok        <= w_rd_in;
      r_rd_bank      <= r_front_sel;
      if (w_flip) begin
        r_front_sel <= ~r_front_sel;
      end
    end
  end

  fb_bank #(.DATA_WIDTH(PIXEL_WIDTH), .DATA_N(NPIX)) u_bank0 (
    .i_clk  (i_clk),
    .i_we   (w_we0),
    .i_waddr(w_waddr),
    .i_wdata(w_wdata),
    .i_raddr(w_rd_addr),
    .o_rdata(w_q0)
  );

  fb_bank #(.DATA_WIDTH(PIXEL_WIDTH), .DATA_N(NPIX)) u_bank1 (
    .i_clk  (i_clk),
    .i_we   (w_we1),
    .i_waddr(w_waddr),
    .i_wdata(w_wdata),
    .i_raddr(w_rd_addr),
    .o_rdata(w_q1)
  );

  assign o_rd_data      = r_rd_ok ? (r_rd_bank ? w_q1 : w_q0) : '0;
  assign o_swap_pending = r_swap_pending;
  assign o_swap_done    = r_swap_done;
  assign o_front_sel    = r_front_sel;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Directed bench for fb_swap_ctrl: table-driven pixel writes/reads plus flip corner sequences.
module tb_fb_swap_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  rd_x = '0;
  logic [7:0]  rd_y = '0;
  logic [15:0] rd_data;
  logic        wr_en = 1'b0;
  logic [8:0]  wr_x = '0;
  logic [7:0]  wr_y = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ready;
  logic        swap_req = 1'b0;
  logic        vsync = 1'b0;
  logic        swap_pending;
  logic        swap_done;
  logic        front_sel;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [8:0]  x;
    logic [7:0]  y;
    logic [15:0] d;
  } pix_vec_t;

  pix_vec_t wvec[6];
  pix_vec_t rvec[7];

  fb_swap_ctrl #(
    .DISPLAY_WIDTH (320),
    .DISPLAY_HEIGHT(240),
    .PIXEL_WIDTH   (16),
    .CLEAR_VALUE   (16'h1234)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_rd_x        (rd_x),
    .i_rd_y        (rd_y),
    .o_rd_data     (rd_data),
    .i_wr_en       (wr_en),
    .i_wr_x        (wr_x),
    .i_wr_y        (wr_y),
    .i_wr_data     (wr_data),
    .o_wr_ready    (wr_ready),
    .i_swap_req    (swap_req),
    .i_vsync       (vsync),
    .o_swap_pending(swap_pending),
    .o_swap_done   (swap_done),
    .o_front_sel   (front_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr_pix(input logic [8:0] x, input logic [7:0] y, input logic [15:0] d);
    wr_en = 1'b1; wr_x = x; wr_y = y; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [8:0] x, input logic [7:0] y,
                        input logic [15:0] exp);
    rd_x = x; rd_y = y;
    @(negedge clk);
    chk(name, {16'h0, rd_data}, {16'h0, exp});
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_front"},   {31'h0, front_sel},    32'h0);
    chk({tag, "_rd"},      {16'h0, rd_data},      32'h0);
    chk({tag, "_ready"},   {31'h0, wr_ready},     32'h1);
    chk({tag, "_pending"}, {31'h0, swap_pending}, 32'h0);
    chk({tag, "_done"},    {31'h0, swap_done},    32'h0);
  endtask

  initial begin
    int n_done;
    int cnt;

    wvec[0] = '{9'd5,   8'd2,   16'hABCD};
    wvec[1] = '{9'd80,  8'd11,  16'h1111};
    wvec[2] = '{9'd400, 8'd10,  16'h2222};
    wvec[3] = '{9'd0,   8'd0,   16'h0F0F};
    wvec[4] = '{9'd319, 8'd239, 16'hBEEF};
    wvec[5] = '{9'd3,   8'd240, 16'h3333};

    rvec[0] = '{9'd5,   8'd2,   16'hABCD};
    rvec[1] = '{9'd80,  8'd11,  16'h1111};
    rvec[2] = '{9'd0,   8'd0,   16'h0F0F};
    rvec[3] = '{9'd319, 8'd239, 16'hBEEF};
    rvec[4] = '{9'd320, 8'd0,   16'h0000};
    rvec[5] = '{9'd0,   8'd240, 16'h0000};
    rvec[6] = '{9'd511, 8'd255, 16'h0000};

    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

`ifndef FB_CLEAR_ON_SWAP_EN
    // Fill bank 1 (back); (400,10) would alias (80,11) without the range check.
    for (int i = 0; i < 6; i++) begin
      wr_pix(wvec[i].x, wvec[i].y, wvec[i].d);
    end

    pulse_swap();
    chk("req_pending", {31'h0, swap_pending}, 32'h1);
    chk("req_front",   {31'h0, front_sel},    32'h0);
    pulse_vsync();
    chk("flip_front",   {31'h0, front_sel},    32'h1);
    chk("flip_done",    {31'h0, swap_done},    32'h1);
    chk("flip_pending", {31'h0, swap_pending}, 32'h0);
    @(negedge clk);
    chk("done_pulse", {31'h0, swap_done}, 32'h0);

    for (int i = 0; i < 7; i++) begin
      rd_chk($sformatf("rd_vec%0d", i), rvec[i].x, rvec[i].y, rvec[i].d);
    end

    // swap_req and vsync together in IDLE: accepted, but the flip waits.
    wr_pix(9'd5, 8'd2, 16'h5555);
    swap_req = 1'b1; vsync = 1'b1;
    @(negedge clk);
    swap_req = 1'b0; vsync = 1'b0;
    chk("same_pending", {31'h0, swap_pending}, 32'h1);
    chk("same_front",   {31'h0, front_sel},    32'h1);
    @(negedge clk);
    // Read presented on the flip edge comes from the old front bank.
    rd_x = 9'd5; rd_y = 8'd2;
    pulse_vsync();
    chk("edge_rd_old", {16'h0, rd_data},   {16'h0, 16'hABCD});
    chk("same_flip",   {31'h0, front_sel}, 32'h0);
    @(negedge clk);
    chk("edge_rd_new", {16'h0, rd_data},   {16'h0, 16'h5555});

    // Write on the flip edge lands in the pre-flip back bank (bank 1).
    pulse_swap();
    wr_en = 1'b1; wr_x = 9'd80; wr_y = 8'd11; wr_data = 16'h7777;
    vsync = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; vsync = 1'b0;
    chk("wflip_front", {31'h0, front_sel}, 32'h1);
    rd_chk("wflip_rd", 9'd80, 8'd11, 16'h7777);

    // Two requests before one vsync -> exactly one flip.
    pulse_swap();
    @(negedge clk);
    pulse_swap();
    n_done = 0;
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (swap_done) n_done++;
      @(negedge clk);
    end
    chk("dbl_done_cnt", n_done,               32'd1);
    chk("dbl_front",    {31'h0, front_sel},   32'h0);
    pulse_vsync();
    chk("idle_vsync_front",   {31'h0, front_sel},    32'h0);
    chk("idle_vsync_pending", {31'h0, swap_pending}, 32'h0);

    // Reset while a flip is pending abandons it.
    pulse_swap();
    pulse_vsync();
    chk("pre_rst_front", {31'h0, front_sel}, 32'h1);
    pulse_swap();
    chk("pre_rst_pending", {31'h0, swap_pending}, 32'h1);
    #2 rst = 1'b1;
    #1 chk_reset_state("rst_pend");
    @(negedge clk);
    rst = 1'b0;
    pulse_vsync();
    chk("post_rst_noflip", {31'h0, front_sel}, 32'h0);
`else
    wr_pix(9'd5, 8'd2, 16'hABCD);
    pulse_swap();
    pulse_vsync();
    chk("clr_front", {31'h0, front_sel}, 32'h1);
    // Count the wr_ready-low window; a write in the middle must be dropped.
    cnt = 0;
    while (!wr_ready && cnt < 80000) begin
      if (cnt == 10000) begin
        wr_en = 1'b1; wr_x = 9'd7; wr_y = 8'd7; wr_data = 16'h9999;
      end else begin
        wr_en = 1'b0;
      end
      cnt++;
      @(negedge clk);
    end
    wr_en = 1'b0;
    chk("clr_len", cnt, 32'd76800);
    chk("clr_ready_back", {31'h0, wr_ready}, 32'h1);

    pulse_swap();
    pulse_vsync();
    chk("clr2_front", {31'h0, front_sel}, 32'h0);
    chk("clr2_ready", {31'h0, wr_ready},  32'h0);
    rd_chk("clr_rd0", 9'd0,   8'd0,   16'h1234);
    rd_chk("clr_rd1", 9'd7,   8'd7,   16'h1234);
    rd_chk("clr_rd2", 9'd319, 8'd239, 16'h1234);
    rd_chk("clr_rd3", 9'd160, 8'd120, 16'h1234);
    rd_chk("clr_rd4", 9'd5,   8'd2,   16'h1234);

    // Request during the sweep is latched; reset near address 1000 abandons everything.
    pulse_swap();
    chk("clr_req_pending", {31'h0, swap_pending}, 32'h1);
    repeat (993) @(negedge clk);
    chk("mid_clr_ready", {31'h0, wr_ready}, 32'h0);
    #2 rst = 1'b1;
    #1 chk_reset_state("rst_clr");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'h0, wr_ready},     32'h1);
    chk("post_rst_pend",  {31'h0, swap_pending}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
